// File: rtl/l1i_mau.sv
// Line-fill engine for the L1 instruction cache: fetches one line as a sequence
// of single-word memory reads and returns the assembled line with a one-cycle ack.
module l1i_mau #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 128,
    parameter int BUS_WIDTH  = 32,
    parameter int BEATS      = LINE_SIZE / BUS_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mau_req_val,
    input  logic [ADDR_WIDTH-1:0] mau_req_addr,
    output logic                  mau_req_ack,
    output logic [LINE_SIZE-1:0]  mau_ack_data,
    output logic                  mem_req_val,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ack,
    input  logic                  mem_rsp_val,
    input  logic [BUS_WIDTH-1:0]  mem_rsp_data,
    output logic                  busy
);

    localparam int                    CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]      LAST       = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'(LINE_SIZE / 8 - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(BUS_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [LINE_SIZE-1:0]    line_q;

    always_comb begin
        state_d     = state_q;
        mem_req_val = 1'b0;
        mau_req_ack = 1'b0;
        case (state_q)
            IDLE: if (mau_req_val) state_d = REQ;
            REQ: begin
                mem_req_val = 1'b1;
                if (mem_req_ack) state_d = WAIT;
            end
            WAIT: if (mem_rsp_val) state_d = (cnt_q == LAST) ? DONE : REQ;
            DONE: begin
                // Request line is still high here; it is only sampled in IDLE.
                mau_req_ack = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign mau_ack_data = line_q;
    assign mem_req_addr = base_q + ADDR_WIDTH'(cnt_q) * BEAT_BYTES;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && mau_req_val) begin
                base_q <= mau_req_addr & ~OFF_MASK;
                cnt_q  <= '0;
            end
            if (state_q == WAIT && mem_rsp_val) begin
                for (int i = 0; i < BEATS; i++) begin
                    if (cnt_q == CNT_W'(i)) line_q[i*BUS_WIDTH +: BUS_WIDTH] <= mem_rsp_data;
                end
                // Counter parks on the last beat so it never wraps inside a fill.
                if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_l1i_mau.sv
// Directed bench for l1i_mau: 4-beat instance driven by an inline memory model,
// plus a single-beat instance checked cycle by cycle.
module tb_l1i_mau;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mau_req_val;
    logic [31:0]  mau_req_addr;
    logic         mau_req_ack;
    logic [127:0] mau_ack_data;
    logic         mem_req_val;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ack;
    logic         mem_rsp_val;
    logic [31:0]  mem_rsp_data;
    logic         busy;

    logic         s_req_val;
    logic [31:0]  s_req_addr;
    logic         s_req_ack;
    logic [31:0]  s_ack_data;
    logic         s_mem_val;
    logic [31:0]  s_mem_addr;
    logic         s_mem_ack;
    logic         s_rsp_val;
    logic [31:0]  s_rsp_data;
    logic         s_busy;

    int checks   = 0;
    int failures = 0;
    int ack_dly[4];
    int rsp_dly[4];

    always #5 clk = ~clk;

    l1i_mau dut (
        .clk(clk), .rst_n(rst_n),
        .mau_req_val(mau_req_val), .mau_req_addr(mau_req_addr),
        .mau_req_ack(mau_req_ack), .mau_ack_data(mau_ack_data),
        .mem_req_val(mem_req_val), .mem_req_addr(mem_req_addr),
        .mem_req_ack(mem_req_ack), .mem_rsp_val(mem_rsp_val),
        .mem_rsp_data(mem_rsp_data), .busy(busy)
    );

    l1i_mau #(.LINE_SIZE(32)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .mau_req_val(s_req_val), .mau_req_addr(s_req_addr),
        .mau_req_ack(s_req_ack), .mau_ack_data(s_ack_data),
        .mem_req_val(s_mem_val), .mem_req_addr(s_mem_addr),
        .mem_req_ack(s_mem_ack), .mem_rsp_val(s_rsp_val),
        .mem_rsp_data(s_rsp_data), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one fill on the 4-beat instance with word = address memory data.
    // Returns at the negedge of the ack cycle, or of cycle abort_cyc if nonzero.
    task automatic fill(input logic [31:0] a, input logic [31:0] base,
                        input int exp_cyc, input int abort_cyc);
        int beat = 0;
        int wcnt = 0;
        int cyc  = 0;
        bit pend = 1'b0;
        logic [127:0] exp_line;
        exp_line     = {base + 32'hC, base + 32'h8, base + 32'h4, base};
        mau_req_val  = 1'b1;
        mau_req_addr = a;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            mem_req_ack = 1'b0;
            mem_rsp_val = 1'b0;
            if (cyc == 1) mau_req_addr = 32'hFFFF_FFF0;
            if (cyc == abort_cyc) return;
            if (mau_req_ack) begin
                chk("ack_cycle", cyc, exp_cyc);
                chk("ack_data", mau_ack_data, exp_line);
                chk("beat_count", beat, 4);
                return;
            end
            if (mem_req_val && beat < 4) begin
                chk("beat_addr", mem_req_addr, base + 32'(beat) * 32'd4);
                if (wcnt == ack_dly[beat]) begin
                    mem_req_ack = 1'b1;
                    pend = 1'b1;
                    wcnt = 0;
                end else wcnt++;
            end else if (pend) begin
                if (wcnt == rsp_dly[beat]) begin
                    mem_rsp_val  = 1'b1;
                    mem_rsp_data = base + 32'(beat) * 32'd4;
                    pend = 1'b0;
                    wcnt = 0;
                    beat++;
                end else wcnt++;
            end
        end
        chk("fill_timeout", cyc, exp_cyc);
    endtask

    task automatic after_ack(input logic drop);
        @(negedge clk);
        chk("ack_single_pulse", mau_req_ack, 1'b0);
        chk("idle_after_ack", busy, 1'b0);
        if (drop) mau_req_val = 1'b0;
    endtask

    task automatic clear_dly();
        for (int i = 0; i < 4; i++) begin
            ack_dly[i] = 0;
            rsp_dly[i] = 0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mau_req_val = 1'b0; mau_req_addr = '0;
        mem_req_ack = 1'b0; mem_rsp_val = 1'b0; mem_rsp_data = '0;
        s_req_val = 1'b0; s_req_addr = '0;
        s_mem_ack = 1'b0; s_rsp_val = 1'b0; s_rsp_data = '0;
        clear_dly();
        repeat (3) @(negedge clk);
        chk("rst_ack", mau_req_ack, 1'b0);
        chk("rst_mem_val", mem_req_val, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", mau_ack_data, 128'h0);
        chk("rst_s_busy", s_busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic zero-wait fill; data must hold after the ack.
        fill(32'h0000_1230, 32'h0000_1230, 9, 0);
        after_ack(1'b1);
        chk("data_hold", mau_ack_data, 128'h0000123C_00001238_00001234_00001230);

        // Stalled bus.
        ack_dly[1] = 3;
        rsp_dly[2] = 5;
        fill(32'h0000_1230, 32'h0000_1230, 17, 0);
        after_ack(1'b1);
        clear_dly();

        // Back-to-back with request held through the ack cycle.
        fill(32'h0000_1000, 32'h0000_1000, 9, 0);
        after_ack(1'b0);
        fill(32'h0000_2000, 32'h0000_2000, 9, 0);
        after_ack(1'b1);

        // Misaligned request address.
        fill(32'h0000_1237, 32'h0000_1230, 9, 0);
        after_ack(1'b1);

        // Reset during WAIT of beat 2, then a spurious response.
        fill(32'h0000_3000, 32'h0000_3000, 0, 6);
        chk("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        mau_req_val = 1'b0;
        #1;
        chk("rst_wait_busy", busy, 1'b0);
        chk("rst_wait_ack", mau_req_ack, 1'b0);
        chk("rst_wait_mem_val", mem_req_val, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rsp_val  = 1'b1;
        mem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rsp_val = 1'b0;
        chk("spurious_busy", busy, 1'b0);
        chk("spurious_mem_val", mem_req_val, 1'b0);
        chk("spurious_data", mau_ack_data, 128'h0);

        // Reset during REQ of beat 2: request valid must fall at once.
        fill(32'h0000_3000, 32'h0000_3000, 0, 5);
        chk("pre_rst_mem_val", mem_req_val, 1'b1);
        rst_n = 1'b0;
        mau_req_val = 1'b0;
        #1;
        chk("rst_req_mem_val", mem_req_val, 1'b0);
        chk("rst_req_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill(32'h0000_4000, 32'h0000_4000, 9, 0);
        after_ack(1'b1);

        // Single-beat instance: ack in cycle 3.
        s_req_val  = 1'b1;
        s_req_addr = 32'h0000_0055;
        @(negedge clk);
        chk("s_c1_mem_val", s_mem_val, 1'b1);
        chk("s_c1_addr", s_mem_addr, 32'h0000_0054);
        s_mem_ack = 1'b1;
        @(negedge clk);
        s_mem_ack = 1'b0;
        chk("s_c2_mem_val", s_mem_val, 1'b0);
        chk("s_c2_ack", s_req_ack, 1'b0);
        s_rsp_val  = 1'b1;
        s_rsp_data = 32'hCAFE_F00D;
        @(negedge clk);
        s_rsp_val = 1'b0;
        chk("s_c3_ack", s_req_ack, 1'b1);
        chk("s_c3_data", s_ack_data, 32'hCAFE_F00D);
        @(negedge clk);
        s_req_val = 1'b0;
        chk("s_c4_ack", s_req_ack, 1'b0);
        chk("s_c4_busy", s_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
